// File: rtl/loadable_ram.sv
// rtl/loadable_ram.sv - run-time loadable lookup RAM with stream loader and registered read port
// Filled in ascending order from a valid/ready word stream; reads behave like the lookup ROM.

module loadable_ram #(
  parameter int gAddressWidth = 4,
  parameter int gDataWidth    = 8
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iStart,
  input  logic                     iWriteValid,
  input  logic [gDataWidth-1:0]    iWriteData,
  output logic                     oWriteReady,
  output logic                     oBusy,
  output logic                     oLoadDone,
  input  logic [gAddressWidth-1:0] iAddress,
  output logic [gDataWidth-1:0]    oData
);

  localparam int Depth = 1 << gAddressWidth;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic [gAddressWidth-1:0] count_q;
  logic                     busy_q;
  logic                     done_q;
  logic [gDataWidth-1:0]    data_q;
  logic [gDataWidth-1:0]    mem_q [Depth];
  logic                     accept;
  logic                     last_word;

  // iStart wins over a same-cycle word, so the word is never acknowledged
  assign oWriteReady = busy_q && !iStart && !iReset;
  assign accept      = oWriteReady && iWriteValid;
  assign last_word   = &count_q;

  assign oBusy     = busy_q;
  assign oLoadDone = done_q;
  assign oData     = data_q;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iStart) begin
            state_q <= LOAD;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (iStart) begin
            count_q <= '0;
          end else if (iWriteValid) begin
            count_q <= count_q + 1'b1;
            if (last_word) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (iStart) begin
            state_q <= LOAD;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset so it maps onto plain RAM
  always_ff @(posedge iClock) begin
    if (accept) begin
      mem_q[count_q] <= iWriteData;
    end
  end

  // Nonblocking read of the array gives read-before-write on address collisions
  always_ff @(posedge iClock) begin
    if (iReset) begin
      data_q <= '0;
    end else begin
      data_q <= mem_q[iAddress];
    end
  end

endmodule

// File: tb/tb_loadable_ram.sv
// tb/tb_loadable_ram.sv - directed self-checking bench for loadable_ram
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.

module tb_loadable_ram;

  logic       iClock;
  logic       iReset;
  logic       iStart;
  logic       iWriteValid;
  logic [7:0] iWriteData;
  logic       oWriteReady;
  logic       oBusy;
  logic       oLoadDone;
  logic [3:0] iAddress;
  logic [7:0] oData;

  int n_checks = 0;
  int n_fail   = 0;

  loadable_ram #(
    .gAddressWidth(4),
    .gDataWidth   (8)
  ) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iStart     (iStart),
    .iWriteValid(iWriteValid),
    .iWriteData (iWriteData),
    .oWriteReady(oWriteReady),
    .oBusy      (oBusy),
    .oLoadDone  (oLoadDone),
    .iAddress   (iAddress),
    .oData      (oData)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic start_load();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    #1;
    check_eq("start_busy", {31'd0, oBusy}, 32'd1);
    check_eq("start_ready", {31'd0, oWriteReady}, 32'd1);
    check_eq("start_done_low", {31'd0, oLoadDone}, 32'd0);
  endtask

  // Gapped mode offers a word on even cycles only: 16 words over 31 cycles
  task automatic load_seq(input logic [7:0] base, input bit gapped);
    int n;
    int k;
    n = gapped ? 31 : 16;
    k = 0;
    for (int c = 0; c < n; c++) begin
      if (!gapped || (c % 2 == 0)) begin
        iWriteValid = 1'b1;
        iWriteData  = base + 8'(k);
        k++;
      end else begin
        iWriteValid = 1'b0;
      end
      tick();
      check_eq("load_done_timing", {31'd0, oLoadDone}, {31'd0, (c == n - 1)});
    end
    iWriteValid = 1'b0;
    check_eq("load_busy_end", {31'd0, oBusy}, 32'd0);
  endtask

  task automatic readback(input logic [7:0] base);
    for (int a = 0; a < 16; a++) begin
      iAddress = 4'(a);
      tick();
      check_eq("readback", {24'd0, oData}, {24'd0, base + 8'(a)});
    end
  endtask

  initial begin
    iReset      = 1'b1;
    iStart      = 1'b1;
    iWriteValid = 1'b1;
    iWriteData  = 8'hEE;
    iAddress    = 4'd0;

    tick();
    tick();
    check_eq("rst_data", {24'd0, oData}, 32'd0);
    check_eq("rst_busy", {31'd0, oBusy}, 32'd0);
    check_eq("rst_done", {31'd0, oLoadDone}, 32'd0);
    check_eq("rst_ready", {31'd0, oWriteReady}, 32'd0);

    iReset      = 1'b0;
    iStart      = 1'b0;
    iWriteValid = 1'b0;
    tick();
    check_eq("idle_busy", {31'd0, oBusy}, 32'd0);
    check_eq("idle_done", {31'd0, oLoadDone}, 32'd0);
    check_eq("idle_ready", {31'd0, oWriteReady}, 32'd0);

    // Continuous full load
    start_load();
    load_seq(8'hA0, 1'b0);
    readback(8'hA0);

    // Gapped valid
    start_load();
    load_seq(8'h60, 1'b1);
    readback(8'h60);

    // Abort after 5 words, restart collides with a valid word
    start_load();
    for (int i = 0; i < 5; i++) begin
      iWriteValid = 1'b1;
      iWriteData  = 8'h11 + 8'(i);
      tick();
    end
    check_eq("abort_busy_mid", {31'd0, oBusy}, 32'd1);
    iStart      = 1'b1;
    iWriteData  = 8'h99;
    #1;
    check_eq("abort_ready_low", {31'd0, oWriteReady}, 32'd0);
    tick();
    iStart      = 1'b0;
    iWriteValid = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, oBusy}, 32'd1);
    check_eq("abort_ready", {31'd0, oWriteReady}, 32'd1);
    load_seq(8'h20, 1'b0);
    readback(8'h20);

    // Read-during-write at address 3 (holds 0x23)
    start_load();
    for (int i = 0; i < 16; i++) begin
      iWriteValid = 1'b1;
      iWriteData  = (i == 3) ? 8'h55 : 8'h50 + 8'(i);
      if (i == 3) iAddress = 4'd3;
      tick();
      if (i == 3) begin
        check_eq("rdw_old", {24'd0, oData}, 32'h23);
      end
      if (i == 4) begin
        check_eq("rdw_new", {24'd0, oData}, 32'h55);
      end
    end
    iWriteValid = 1'b0;
    check_eq("rdw_done", {31'd0, oLoadDone}, 32'd1);

    // Reload from DONE
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    #1;
    check_eq("reload_done_low", {31'd0, oLoadDone}, 32'd0);
    check_eq("reload_busy", {31'd0, oBusy}, 32'd1);
    load_seq(8'h70, 1'b0);
    readback(8'h70);
    tick();
    check_eq("final_done_held", {31'd0, oLoadDone}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
